ws2812_frame_scheduler: RTL



---
 rtl/ws2812_pkg.sv | 24 ++
 rtl/ws2812_tick_gen.sv | 36 +++
 rtl/ws2812_frame_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 frame scheduler.
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        TX,
        GAP
    } state_e;

    // 300 us latch gap, 60 Hz refresh, 20 ms frame abort at 200 MHz
    localparam int unsigned DEF_RESET_CYCLES = 60000;
    localparam int unsigned DEF_AUTO_PERIOD  = 3333333;
    localparam int unsigned DEF_TX_TIMEOUT   = 4000000;

    localparam int unsigned DROP_W  = 8;
    localparam int unsigned FRAME_W = 16;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ws2812_tick_gen.sv
// Free-running period counter; tick is high on the last count while enabled.
module ws2812_tick_gen
    import ws2812_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_AUTO_PERIOD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned   W    = cnt_width(PERIOD);
    localparam logic [W-1:0]  LAST = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Disabled counter parks at zero so the first tick is a full period after enable
    always_comb begin
        cnt_d = '0;
        if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Frame refresh sequencer: trigger merge, RAM arbitration, read pulse, timeout and latch gap.
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned AUTO_PERIOD  = DEF_AUTO_PERIOD,
    parameter int unsigned TX_TIMEOUT   = DEF_TX_TIMEOUT
) (
    input  logic               clk,
    input  logic               Rst,
    input  logic               sw_trig,
    input  logic               auto_en,
    input  logic               wr_busy,
    input  logic               tx_done,
    input  logic               clr_status,
    output logic               read_out,
    output logic               wr_gnt,
    output logic               frame_busy,
    output logic               err_timeout,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned       GAP_W    = cnt_width(RESET_CYCLES);
    localparam int unsigned       TMO_W    = cnt_width(TX_TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(RESET_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TX_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 pending_q, pending_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 read_q, gnt_q, busy_q;
    logic                 err_q, err_d;
    logic [DROP_W-1:0]    drop_q, drop_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 auto_tick;
    logic                 trig;
    logic                 timeout_hit;

    ws2812_tick_gen #(
        .PERIOD (AUTO_PERIOD)
    ) u_tick (
        .clk_i  (clk),
        .rst_i  (Rst),
        .en_i   (auto_en),
        .tick_o (auto_tick)
    );

    assign trig = sw_trig | auto_tick;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        gap_d       = '0;
        tmo_d       = '0;
        err_d       = err_q;
        drop_d      = drop_q;
        frame_d     = frame_q;
        timeout_hit = 1'b0;

        if (clr_status) begin
            err_d  = 1'b0;
            drop_d = '0;
        end

        // FIRE consumes the pending request; a trigger in that same cycle becomes the next one
        if (state_q == FIRE) begin
            pending_d = trig;
        end else if (trig) begin
            pending_d = 1'b1;
            if (pending_q) begin
                drop_d = (drop_q == '1) ? drop_q : drop_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pending_q || trig) state_d = ARM;
            end
            ARM: begin
                if (!wr_busy) state_d = FIRE;
            end
            FIRE: begin
                frame_d = frame_q + 1'b1;
                tmo_d   = tmo_q + 1'b1;
                state_d = TX;
            end
            TX: begin
                tmo_d = tmo_q + 1'b1;
                if (tx_done) begin
                    state_d = GAP;
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = GAP;
                    timeout_hit = 1'b1;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = (pending_q || trig) ? ARM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout_hit) err_d = 1'b1;
    end

    // Outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            gap_q     <= '0;
            tmo_q     <= '0;
            read_q    <= 1'b0;
            gnt_q     <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            read_q    <= (state_d == FIRE);
            gnt_q     <= (state_d == IDLE) || (state_d == GAP);
            busy_q    <= (state_d != IDLE);
            err_q     <= err_d;
            drop_q    <= drop_d;
            frame_q   <= frame_d;
        end
    end

    assign read_out    = read_q;
    assign wr_gnt      = gnt_q;
    assign frame_busy  = busy_q;
    assign err_timeout = err_q;
    assign drop_cnt    = drop_q;
    assign frame_cnt   = frame_q;

endmodule
